// File: rtl/xm23_psw_pkg.sv
// Shared Program Status Word layout for the XM23 core: bit positions, the
// reserved-bit mask, a structured view of the word and the entry-PSW builder.
package xm23_psw_pkg;

   localparam int C           = 0;
   localparam int Z           = 1;
   localparam int N           = 2;
   localparam int SLP         = 3;
   localparam int V           = 4;
   localparam int CUR_PRI_LSB = 5;
   localparam int PRV_PRI_LSB = 13;

   localparam logic [15:0] RSVD_MASK = 16'h1F00;

   typedef struct packed {
      logic [2:0] prv_pri;
      logic [4:0] rsvd;
      logic [2:0] cur_pri;
      logic       v;
      logic       slp;
      logic       n;
      logic       z;
      logic       c;
   } psw_t;

   // Exception entry clears every flag (including SLP, which wakes the core)
   // and demotes the running priority into the previous-priority field.
   function automatic logic [15:0] entry_psw(input logic [15:0] curPsw,
                                             input logic [2:0]  newPri);
      psw_t oldPsw;
      psw_t newPsw;
      oldPsw         = psw_t'(curPsw);
      newPsw         = '0;
      newPsw.prv_pri = oldPsw.cur_pri;
      newPsw.cur_pri = newPri;
      return newPsw;
   endfunction

   function automatic logic [15:0] reset_psw(input logic [2:0] pri);
      psw_t p;
      p         = '0;
      p.cur_pri = pri;
      return p;
   endfunction

endpackage

// File: rtl/psw_shadow_stack.sv
// Small LIFO holding PSWs saved on exception entry. Overflow and underflow
// are blocked here too, so the parent can never corrupt the level count.
module psw_shadow_stack
   import xm23_psw_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  top_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [LW-1:0] level_q;
   logic [AW-1:0] topIdx;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

   // Low bits of the level wrap to DEPTH-1 when full, which is the top slot.
   assign topIdx = level_q[AW-1:0] - 1'b1;
   assign top_o  = empty_o ? '0 : mem_q[topIdx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_i && !full_o) begin
         mem_q[level_q[AW-1:0]] <= data_i;
         level_q                <= level_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         level_q <= level_q - 1'b1;
      end
   end

endmodule

// File: rtl/psw_reg_unit.sv
// Architectural PSW register: applies masked flag updates from the update
// stage and saves/restores the PSW around exceptions via a shadow stack.
module psw_reg_unit
   import xm23_psw_pkg::*;
#(
   parameter int         STK_DEPTH = 4,
   parameter logic [2:0] RESET_PRI = 3'd7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [15:0]                psw_in,
   input  logic [15:0]                psw_msk,
   input  logic                       psw_wr_en,
   input  logic                       exc_entry,
   input  logic [2:0]                 exc_pri,
   input  logic                       exc_return,
   output logic [15:0]                psw_q,
   output logic [15:0]                psw_next,
   output logic                       sleep,
   output logic                       exc_ack,
   output logic                       stk_fault,
   output logic [$clog2(STK_DEPTH):0] stk_level
);

   localparam int LW = $clog2(STK_DEPTH) + 1;

   logic [15:0] psw_d;
   logic        ack_d;
   logic        ack_q;
   logic        fault_d;
   logic        fault_q;
   logic        pushEn;
   logic        popEn;
   logic [15:0] stkTop;
   logic        stkFull;
   logic        stkEmpty;

   psw_shadow_stack #(
      .DEPTH (STK_DEPTH),
      .W     (16),
      .LW    (LW)
   ) uStack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (pushEn),
      .pop_i   (popEn),
      .data_i  (psw_q),
      .top_o   (stkTop),
      .full_o  (stkFull),
      .empty_o (stkEmpty),
      .level_o (stk_level)
   );

   // Entry beats return beats the masked write; a rejected entry still
   // squashes the write because the faulting instruction never retires.
   always_comb begin
      psw_d   = psw_q;
      pushEn  = 1'b0;
      popEn   = 1'b0;
      ack_d   = 1'b0;
      fault_d = 1'b0;
      if (exc_entry) begin
         if (stkFull) begin
            fault_d = 1'b1;
         end else begin
            pushEn = 1'b1;
            ack_d  = 1'b1;
            psw_d  = entry_psw(psw_q, exc_pri);
         end
      end else if (exc_return) begin
         if (stkEmpty) begin
            fault_d = 1'b1;
         end else begin
            popEn = 1'b1;
            ack_d = 1'b1;
            psw_d = stkTop;
         end
      end else if (psw_wr_en) begin
         psw_d = ((psw_q & ~psw_msk) | (psw_in & psw_msk)) & ~RSVD_MASK;
      end
   end

   assign psw_next  = psw_d;
   assign sleep     = psw_q[SLP];
   assign exc_ack   = ack_q;
   assign stk_fault = fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psw_q   <= reset_psw(RESET_PRI);
         ack_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         psw_q   <= psw_d;
         ack_q   <= ack_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_psw_reg_unit.sv
// Directed self-checking bench for psw_reg_unit: masked writes, reserved
// bits, exception entry/return, stack overflow/underflow and async reset.
module tb_psw_reg_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] psw_in;
   logic [15:0] psw_msk;
   logic        psw_wr_en;
   logic        exc_entry;
   logic [2:0]  exc_pri;
   logic        exc_return;
   logic [15:0] psw_q;
   logic [15:0] psw_next;
   logic        sleep;
   logic        exc_ack;
   logic        stk_fault;
   logic [2:0]  stk_level;

   int errors;
   int checks;

   psw_reg_unit #(
      .STK_DEPTH (4),
      .RESET_PRI (3'd7)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .psw_in     (psw_in),
      .psw_msk    (psw_msk),
      .psw_wr_en  (psw_wr_en),
      .exc_entry  (exc_entry),
      .exc_pri    (exc_pri),
      .exc_return (exc_return),
      .psw_q      (psw_q),
      .psw_next   (psw_next),
      .sleep      (sleep),
      .exc_ack    (exc_ack),
      .stk_fault  (stk_fault),
      .stk_level  (stk_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request at the falling edge, lets one rising edge pass,
   // then removes the pulses so outputs can be sampled 1ns after the edge.
   task automatic applyStimulus(input logic en, input logic [15:0] din, input logic [15:0] msk,
                                input logic ent, input logic [2:0] pri, input logic ret);
      @(negedge clk);
      psw_wr_en  = en;
      psw_in     = din;
      psw_msk    = msk;
      exc_entry  = ent;
      exc_pri    = pri;
      exc_return = ret;
      @(posedge clk);
      #1;
      psw_wr_en  = 1'b0;
      exc_entry  = 1'b0;
      exc_return = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      psw_wr_en = 0; psw_in = 0; psw_msk = 0; exc_entry = 0; exc_pri = 0; exc_return = 0;
      #12;
      checks++; if (psw_q !== 16'h00E0) begin errors++; $display("[TB] FAIL reset_psw got=%h exp=00e0", psw_q); end
      checks++; if (stk_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", stk_level); end
      checks++; if (sleep !== 1'b0) begin errors++; $display("[TB] FAIL reset_sleep got=%b exp=0", sleep); end
      checks++; if ({exc_ack, stk_fault} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses got=%b exp=00", {exc_ack, stk_fault}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_masked_write();
      @(negedge clk);
      psw_wr_en = 1; psw_in = 16'h001F; psw_msk = 16'h0017;
      #1;
      checks++; if (psw_next !== 16'h00F7) begin errors++; $display("[TB] FAIL fwd_next got=%h exp=00f7", psw_next); end
      checks++; if (psw_q !== 16'h00E0) begin errors++; $display("[TB] FAIL fwd_hold got=%h exp=00e0", psw_q); end
      @(posedge clk); #1;
      psw_wr_en = 0;
      checks++; if (psw_q !== 16'h00F7) begin errors++; $display("[TB] FAIL mwrite got=%h exp=00f7", psw_q); end
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0, 0);
      checks++; if (psw_q !== 16'h00F7) begin errors++; $display("[TB] FAIL zero_mask got=%h exp=00f7", psw_q); end
      applyStimulus(0, 16'h0000, 16'hFFFF, 0, 0, 0);
      checks++; if (psw_q !== 16'h00F7) begin errors++; $display("[TB] FAIL wr_en_low got=%h exp=00f7", psw_q); end
   endtask

   task automatic test_reserved();
      applyStimulus(1, 16'hFFFF, 16'hFFFF, 0, 0, 0);
      checks++; if (psw_q !== 16'hE0FF) begin errors++; $display("[TB] FAIL reserved got=%h exp=e0ff", psw_q); end
   endtask

   task automatic test_entry_return();
      applyStimulus(1, 16'h00EF, 16'hFFFF, 0, 0, 0);
      checks++; if (psw_q !== 16'h00EF || sleep !== 1'b1) begin errors++; $display("[TB] FAIL setup_sleep got=%h/%b exp=00ef/1", psw_q, sleep); end
      applyStimulus(0, 0, 0, 1, 3'd3, 0);
      checks++; if (psw_q !== 16'hE060) begin errors++; $display("[TB] FAIL entry_psw got=%h exp=e060", psw_q); end
      checks++; if (sleep !== 1'b0) begin errors++; $display("[TB] FAIL entry_wake got=%b exp=0", sleep); end
      checks++; if ({exc_ack, stk_fault} !== 2'b10) begin errors++; $display("[TB] FAIL entry_ack got=%b exp=10", {exc_ack, stk_fault}); end
      checks++; if (stk_level !== 3'd1) begin errors++; $display("[TB] FAIL entry_level got=%0d exp=1", stk_level); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (exc_ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_pulse got=%b exp=0", exc_ack); end
      applyStimulus(1, 16'h0000, 16'hFFFF, 0, 0, 1);
      checks++; if (psw_q !== 16'h00EF || stk_level !== 3'd0) begin errors++; $display("[TB] FAIL return got=%h/%0d exp=00ef/0", psw_q, stk_level); end
      checks++; if ({exc_ack, stk_fault} !== 2'b10) begin errors++; $display("[TB] FAIL return_ack got=%b exp=10", {exc_ack, stk_fault}); end
   endtask

   task automatic test_overflow();
      logic [15:0] pushed [4];
      pushed[0] = 16'hE020; pushed[1] = 16'h2040; pushed[2] = 16'h4060; pushed[3] = 16'h6080;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 1, 3'(i + 1), 0);
         checks++; if (psw_q !== pushed[i] || stk_level !== 3'(i + 1)) begin errors++; $display("[TB] FAIL push%0d got=%h/%0d exp=%h/%0d", i, psw_q, stk_level, pushed[i], i + 1); end
      end
      applyStimulus(1, 16'h0000, 16'hFFFF, 1, 3'd5, 0);
      checks++; if ({exc_ack, stk_fault} !== 2'b01) begin errors++; $display("[TB] FAIL ovf_fault got=%b exp=01", {exc_ack, stk_fault}); end
      checks++; if (psw_q !== 16'h6080 || stk_level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_hold got=%h/%0d exp=6080/4", psw_q, stk_level); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (stk_fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_pulse got=%b exp=0", stk_fault); end
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(0, 0, 0, 0, 0, 1);
         if (i > 0) begin
            checks++; if (psw_q !== pushed[i - 1] || stk_level !== 3'(i)) begin errors++; $display("[TB] FAIL pop%0d got=%h/%0d exp=%h/%0d", i, psw_q, stk_level, pushed[i - 1], i); end
         end else begin
            checks++; if (psw_q !== 16'h00EF || stk_level !== 3'd0) begin errors++; $display("[TB] FAIL pop0 got=%h/%0d exp=00ef/0", psw_q, stk_level); end
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if ({exc_ack, stk_fault} !== 2'b01) begin errors++; $display("[TB] FAIL unf_fault got=%b exp=01", {exc_ack, stk_fault}); end
      checks++; if (psw_q !== 16'h00EF || stk_level !== 3'd0) begin errors++; $display("[TB] FAIL unf_hold got=%h/%0d exp=00ef/0", psw_q, stk_level); end
   endtask

   task automatic test_simultaneous();
      applyStimulus(1, 16'h0000, 16'hFFFF, 1, 3'd2, 1);
      checks++; if (psw_q !== 16'hE040 || stk_level !== 3'd1) begin errors++; $display("[TB] FAIL simul_psw got=%h/%0d exp=e040/1", psw_q, stk_level); end
      checks++; if ({exc_ack, stk_fault} !== 2'b10) begin errors++; $display("[TB] FAIL simul_pulses got=%b exp=10", {exc_ack, stk_fault}); end
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (psw_q !== 16'h00EF) begin errors++; $display("[TB] FAIL simul_restore got=%h exp=00ef", psw_q); end
   endtask

   task automatic test_async_reset();
      applyStimulus(0, 0, 0, 1, 3'd6, 0);
      applyStimulus(0, 0, 0, 1, 3'd5, 0);
      checks++; if (psw_q !== 16'hC0A0 || stk_level !== 3'd2) begin errors++; $display("[TB] FAIL pre_rst got=%h/%0d exp=c0a0/2", psw_q, stk_level); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (psw_q !== 16'h00E0 || stk_level !== 3'd0) begin errors++; $display("[TB] FAIL async_rst got=%h/%0d exp=00e0/0", psw_q, stk_level); end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if ({exc_ack, stk_fault} !== 2'b01 || psw_q !== 16'h00E0) begin errors++; $display("[TB] FAIL rst_stack got=%b/%h exp=01/00e0", {exc_ack, stk_fault}, psw_q); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_masked_write();
      test_reserved();
      test_entry_return();
      test_overflow();
      test_simultaneous();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
